// File: rtl/faddsub_pipe.sv
// rtl/faddsub_pipe.sv - 3-stage binary32 add/subtract with RNE, flush-to-zero and valid/ready flow control
module faddsub_pipe #(
  parameter int          TAGW      = 4,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_op,
  input  logic [31:0]     in_x1,
  input  logic [31:0]     in_x2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            out_ovf,
  output logic            out_unf,
  output logic            out_nv
);

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // ---------------- stage 1: classify, order, align ----------------
  logic [7:0]  e1, e2, el, es, d;
  logic        sa, sb, swap, nan1, nan2, inf1, inf2;
  logic [30:0] m1, m2;
  logic [23:0] sig1, sig2, ml, ms;
  logic [26:0] t, small_al;
  logic [53:0] ext;
  logic        spec;
  logic [31:0] spec_y;
  logic        spec_nv;

  always_comb begin
    e1   = in_x1[30:23];
    e2   = in_x2[30:23];
    sa   = in_x1[31];
    sb   = in_x2[31] ^ in_op;
    nan1 = (e1 == 8'hFF) && (in_x1[22:0] != 23'd0);
    nan2 = (e2 == 8'hFF) && (in_x2[22:0] != 23'd0);
    inf1 = (e1 == 8'hFF) && (in_x1[22:0] == 23'd0);
    inf2 = (e2 == 8'hFF) && (in_x2[22:0] == 23'd0);
    m1   = (e1 == 8'd0) ? 31'd0 : in_x1[30:0];
    m2   = (e2 == 8'd0) ? 31'd0 : in_x2[30:0];
    sig1 = (e1 == 8'd0) ? 24'd0 : {1'b1, in_x1[22:0]};
    sig2 = (e2 == 8'd0) ? 24'd0 : {1'b1, in_x2[22:0]};
    swap = (m2 > m1);
    el   = swap ? e2 : e1;
    es   = swap ? e1 : e2;
    ml   = swap ? sig2 : sig1;
    ms   = swap ? sig1 : sig2;
    d    = el - es;
    t    = {ms, 3'b000};
    ext  = {t, 27'd0} >> d;
    if (d >= 8'd27) small_al = {26'd0, (ms != 24'd0)};
    else            small_al = {ext[53:28], (ext[27:0] != 28'd0)};

    spec    = 1'b0;
    spec_y  = 32'd0;
    spec_nv = 1'b0;
    if (nan1 || nan2) begin
      spec = 1'b1; spec_y = CANON_NAN; spec_nv = 1'b1;
    end else if (inf1 && inf2) begin
      spec = 1'b1;
      if (sa != sb) begin
        spec_y = CANON_NAN; spec_nv = 1'b1;
      end else begin
        spec_y = {sa, 8'hFF, 23'd0};
      end
    end else if (inf1) begin
      spec = 1'b1; spec_y = {sa, 8'hFF, 23'd0};
    end else if (inf2) begin
      spec = 1'b1; spec_y = {sb, 8'hFF, 23'd0};
    end
  end

  logic            s1_v, s1_sl, s1_sub, s1_spec, s1_nv;
  logic [TAGW-1:0] s1_tag;
  logic [7:0]      s1_el;
  logic [23:0]     s1_ml;
  logic [26:0]     s1_sm;
  logic [31:0]     s1_spec_y;

  // ---------------- stage 2: add/sub, normalise ----------------
  logic [27:0]       big, sm, sum;
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] nexp;
  logic              zero, nsign;

  always_comb begin
    big  = {1'b0, s1_ml, 3'b000};
    sm   = {1'b0, s1_sm};
    sum  = s1_sub ? (big - sm) : (big + sm);
    lz   = lzc27(sum[26:0]);
    zero = (sum == 28'd0);
    if (sum[27]) begin
      norm = {sum[27:2], (sum[1:0] != 2'd0)};
      nexp = $signed({2'b00, s1_el}) + 10'sd1;
    end else begin
      norm = sum[26:0] << lz;
      nexp = $signed({2'b00, s1_el}) - $signed({5'd0, lz});
    end
    // an exact cancellation is +0; only a same-sign sum of zeros keeps the sign
    nsign = zero ? (s1_sub ? 1'b0 : s1_sl) : s1_sl;
  end

  logic              s2_v, s2_sign, s2_zero, s2_spec, s2_nv;
  logic [TAGW-1:0]   s2_tag;
  logic signed [9:0] s2_exp;
  logic [26:0]       s2_norm;
  logic [31:0]       s2_spec_y;

  // ---------------- stage 3: round, range check ----------------
  logic              up;
  logic [24:0]       m25;
  logic signed [9:0] exp_r;
  logic [22:0]       frac;
  logic [31:0]       ry;
  logic              rovf, runf, rnv;

  always_comb begin
    up    = s2_norm[2] && (s2_norm[1] || s2_norm[0] || s2_norm[3]);
    m25   = {1'b0, s2_norm[26:3]} + {24'd0, up};
    exp_r = s2_exp + $signed({9'd0, m25[24]});
    frac  = m25[24] ? m25[23:1] : m25[22:0];
    ry    = {s2_sign, exp_r[7:0], frac};
    rovf  = 1'b0;
    runf  = 1'b0;
    rnv   = 1'b0;
    if (s2_spec) begin
      ry  = s2_spec_y;
      rnv = s2_nv;
    end else if (s2_zero) begin
      ry = {s2_sign, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      ry   = {s2_sign, 8'hFF, 23'd0};
      rovf = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      ry   = {s2_sign, 31'd0};
      runf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= 32'd0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      out_nv    <= 1'b0;
    end else if (!stall) begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      out_valid <= s2_v;
      out_y     <= ry;
      out_tag   <= s2_tag;
      out_ovf   <= rovf;
      out_unf   <= runf;
      out_nv    <= rnv;
    end
  end

  // payload registers need no reset: the valid bits gate them
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_tag    <= in_tag;
      s1_sl     <= swap ? sb : sa;
      s1_sub    <= sa ^ sb;
      s1_el     <= el;
      s1_ml     <= ml;
      s1_sm     <= small_al;
      s1_spec   <= spec;
      s1_spec_y <= spec_y;
      s1_nv     <= spec_nv;
      s2_tag    <= s1_tag;
      s2_sign   <= nsign;
      s2_zero   <= zero;
      s2_exp    <= nexp;
      s2_norm   <= norm;
      s2_spec   <= s1_spec;
      s2_spec_y <= s1_spec_y;
      s2_nv     <= s1_nv;
    end
  end

endmodule

// File: tb/tb_faddsub_pipe.sv
// tb/tb_faddsub_pipe.sv - directed scoreboard bench for faddsub_pipe
module tb_faddsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_op;
  logic [31:0] in_x1, in_x2;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
  logic        out_ovf, out_unf, out_nv;

  faddsub_pipe #(.TAGW(4), .CANON_NAN(32'h7FC00000)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_nv(out_nv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  tag;
    logic [2:0]  fl;   // {ovf, unf, nv}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] fi [0:8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_y", out_y, e.y);
        chk("result_tag", 32'(out_tag), 32'(e.tag));
        chk("result_flags", 32'({out_ovf, out_unf, out_nv}), 32'(e.fl));
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the beat is accepted
  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] y, input logic [2:0] fl);
    logic acc;
    acc = 1'b0;
    in_op = op; in_x1 = a; in_x2 = b; in_tag = tag; in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back('{y: y, tag: tag, fl: fl});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_y", out_y, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_flags", 32'({out_ovf, out_unf, out_nv}), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // latency: beat presented in cycle 0, result valid in cycle 3
    in_op = 1'b0; in_x1 = 32'h3F800000; in_x2 = 32'h40000000; in_tag = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    sb.push_back('{y: 32'h40400000, tag: 4'd5, fl: 3'b000});
    @(posedge clk); #1 in_valid = 1'b0;
    chk("latency_c1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_c2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_c3", 32'(out_valid), 32'd1);
    drain();

    // directed arithmetic, issued back to back
    send(1'b1, 32'h3F800001, 32'h3F800000, 4'd1,  32'h34000000, 3'b000);
    send(1'b1, 32'h3F800000, 32'h3F800000, 4'd2,  32'h00000000, 3'b000);
    send(1'b0, 32'h4B800000, 32'h3F800000, 4'd3,  32'h4B800000, 3'b000);
    send(1'b0, 32'h4B800001, 32'h3F800000, 4'd4,  32'h4B800002, 3'b000);
    send(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'd5,  32'h7F800000, 3'b100);
    send(1'b1, 32'h00800001, 32'h00800000, 4'd6,  32'h00000000, 3'b010);
    send(1'b1, 32'h7F800000, 32'h7F800000, 4'd7,  32'h7FC00000, 3'b001);
    send(1'b0, 32'h80000000, 32'h80000000, 4'd8,  32'h80000000, 3'b000);
    send(1'b1, 32'hBF800000, 32'hBF800000, 4'd9,  32'h00000000, 3'b000);
    send(1'b0, 32'h3F800000, 32'h7F800000, 4'd10, 32'h7F800000, 3'b000);
    send(1'b1, 32'h3F800000, 32'hFF800000, 4'd11, 32'h7F800000, 3'b000);
    send(1'b0, 32'h3F800000, 32'h7F800001, 4'd12, 32'h7FC00000, 3'b001);
    send(1'b0, 32'h00000001, 32'h3F800000, 4'd13, 32'h3F800000, 3'b000);
    send(1'b0, 32'h3F800000, 32'hBF800000, 4'd14, 32'h00000000, 3'b000);
    send(1'b1, 32'h40400000, 32'h3F800000, 4'd15, 32'h40000000, 3'b000);
    send(1'b0, 32'hC0000000, 32'h3F800000, 4'd0,  32'hBF800000, 3'b000);
    send(1'b0, 32'hFF800000, 32'hFF800000, 4'd1,  32'hFF800000, 3'b000);
    drain();

    // 8-beat stream with a 4-cycle consumer stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(1'b0, fi[i], 32'h3F800000, 4'(i + 8), fi[i + 1], 3'b000);
      end
      begin
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b0;
        #1;
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    // reset with three beats in flight
    out_ready = 1'b0;
    send(1'b0, 32'h3F800000, 32'h3F800000, 4'd1, 32'h40000000, 3'b000);
    send(1'b0, 32'h40000000, 32'h3F800000, 4'd2, 32'h40400000, 3'b000);
    send(1'b0, 32'h40400000, 32'h3F800000, 4'd3, 32'h40800000, 3'b000);
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_stale_result", 32'(seen), 32'd0);

    send(1'b0, 32'h3F800000, 32'h40000000, 4'd3, 32'h40400000, 3'b000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
